// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter that serializes one 24-bit codec register write onto SCL/SDA.
// Optional macro I2C_ABORT_ON_NACK_EN: a NACKed byte jumps straight to STOP.
module i2c_write_arbiter #(
  parameter int DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [23:0] i_data0,
  input  logic [23:0] i_data1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_nack,
  output logic        o_busy,
  output logic        o_sclk,
  inout  wire         o_sdat,
  output logic        o_oen
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BIT   = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

`ifdef I2C_ABORT_ON_NACK_EN
  localparam logic ABORT = 1'b1;
`else
  localparam logic ABORT = 1'b0;
`endif

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   data_q, data_d;
  logic          sel_q, sel_d;
  logic          ptr_q, ptr_d;
  logic          nflag_q, nflag_d;
  logic          sclk_q, sclk_d;
  logic          sda_q, sda_d;
  logic          oen_q, oen_d;
  logic          done0_q, done1_q, nack_q, busy_q;

  logic          gnt_any, gsel, last, ack_bad;
  logic [4:0]    idx;

  assign gnt_any = i_req0 | i_req1;
  // On a tie the pointer decides; otherwise whichever port is requesting wins.
  assign gsel    = (i_req0 & i_req1) ? ptr_q : i_req1;
  assign last    = (pc_q == PC_LAST);
  assign ack_bad = o_sdat;

  always_comb begin
    state_d = state_q;
    pc_d    = (last || state_q == IDLE || state_q == DONE) ? '0 : pc_q + PW'(1);
    half_d  = half_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    nflag_d = nflag_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = START;
          sel_d   = gsel;
          data_d  = gsel ? i_data1 : i_data0;
        end
      end
      START: begin
        if (last) begin
          state_d = BIT;
          half_d  = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      BIT: begin
        if (last) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else begin
            half_d = 2'd0;
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = ACK;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      ACK: begin
        if (last) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else begin
            // Last cycle of the high phase: the slave's ACK bit is valid here.
            half_d  = 2'd0;
            nflag_d = nflag_q | ack_bad;
            if (byte_q == 2'd2 || (ABORT && ack_bad)) begin
              byte_d  = 2'd0;
              state_d = STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = BIT;
            end
          end
        end
      end
      STOP: begin
        if (last) begin
          if (half_q == 2'd2) begin
            half_d  = 2'd0;
            state_d = DONE;
          end else begin
            half_d = half_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        nflag_d = 1'b0;
        ptr_d   = ~sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    idx    = 5'd23 - {byte_d, 3'b000} - {2'b00, bit_d};
    sclk_d = 1'b1;
    sda_d  = 1'b1;
    oen_d  = 1'b1;
    case (state_d)
      START: sda_d = 1'b0;
      BIT: begin
        sclk_d = half_d[0];
        sda_d  = data_d[idx];
      end
      ACK: begin
        sclk_d = half_d[0];
        oen_d  = 1'b0;
      end
      STOP: begin
        sclk_d = (half_d != 2'd0);
        sda_d  = (half_d == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      half_q  <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      nflag_q <= 1'b0;
      sclk_q  <= 1'b1;
      sda_q   <= 1'b1;
      oen_q   <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      nflag_q <= nflag_d;
      sclk_q  <= sclk_d;
      sda_q   <= sda_d;
      oen_q   <= oen_d;
      done0_q <= (state_d == DONE) && !sel_d;
      done1_q <= (state_d == DONE) && sel_d;
      nack_q  <= (state_d == DONE) && nflag_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Frame payload carries no reset; it is only consumed after a grant reloads it.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
  end

  assign o_gnt0  = i_rst_n & (state_q == IDLE) & gnt_any & ~gsel;
  assign o_gnt1  = i_rst_n & (state_q == IDLE) & gnt_any & gsel;
  assign o_done0 = done0_q;
  assign o_done1 = done1_q;
  assign o_nack  = nack_q;
  assign o_busy  = busy_q;
  assign o_sclk  = sclk_q;
  assign o_oen   = oen_q;
  assign o_sdat  = oen_q ? sda_q : 1'bz;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: frame-level model compared every cycle plus literal anchors.
module tb_i2c_write_arbiter;

  localparam int DIV = 4;
`ifdef I2C_ABORT_ON_NACK_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk, rst_n, req0, req1;
  logic [23:0] data0, data1;
  logic        gnt0, gnt1, done0, done1, nack, busy, sclk, oen;
  wire         sda_bus;
  logic        slave_val;
  logic [2:0]  nack_mask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  int last_done_cyc = 0;
  int gq[$];
  logic [31:0] cap = '0;
  int capn = 0;
  int ackn = 0;

  i2c_write_arbiter #(.DIV(DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_data0(data0), .i_data1(data1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_nack(nack), .o_busy(busy), .o_sclk(sclk), .o_sdat(sda_bus), .o_oen(oen)
  );

  assign sda_bus = oen ? 1'bz : slave_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Bits seen on SCL rising edges while the block drives SDA; ACK windows counted separately.
  always @(posedge sclk) begin
    if (oen === 1'b1) begin
      cap  = {cap[30:0], sda_bus};
      capn = capn + 1;
    end else begin
      ackn = ackn + 1;
    end
  end

  // Frame model: expected pins follow from the phase index since the grant.
  bit          m_active = 1'b0;
  int          m_k, m_p, m_nb, m_ptr = 0, m_sel;
  logic [23:0] m_frame;
  logic [2:0]  m_mask;
  logic        m_nflag;

  always @(negedge clk) begin
    int p, q, j, hb, by, w, s, fb;
    logic e_scl, e_sda, e_oen, e_busy, e_d0, e_d1, e_nk, e_g0, e_g1;
    bit   e_sda_chk, done_now;
    cyc++;
    e_scl = 1; e_sda = 1; e_oen = 1; e_busy = 0; e_d0 = 0; e_d1 = 0; e_nk = 0;
    e_g0 = 0; e_g1 = 0; e_sda_chk = 1; done_now = 0;
    if (!rst_n) begin
      m_active = 0;
      m_ptr = 0;
    end else if (m_active) begin
      p = m_k / DIV;
      e_busy = 1;
      if (m_k == m_p * DIV) begin
        e_d0 = (m_sel == 0);
        e_d1 = (m_sel == 1);
        e_nk = m_nflag;
        done_now = 1;
      end else if (p == 0) begin
        e_sda = 0;
      end else if (p <= 18 * m_nb) begin
        q = p - 1; j = q / 2; hb = q % 2; by = j / 9; w = j % 9;
        e_scl = hb[0];
        if (w < 8) begin
          e_sda = m_frame[23 - by * 8 - w];
        end else begin
          e_oen = 0;
          e_sda_chk = 0;
          slave_val = m_mask[by];
        end
      end else begin
        s = p - 1 - 18 * m_nb;
        e_scl = (s != 0);
        e_sda = (s == 2);
      end
      if (done_now) begin
        m_active = 0;
        m_ptr = 1 - m_sel;
      end else begin
        m_k++;
      end
    end else begin
      if (req0 && req1) m_sel = m_ptr;
      else if (req0)    m_sel = 0;
      else              m_sel = 1;
      if (req0 || req1) begin
        e_g0 = (m_sel == 0);
        e_g1 = (m_sel == 1);
        m_active = 1;
        m_k = 0;
        m_frame = (m_sel == 1) ? data1 : data0;
        m_mask = nack_mask;
        fb = 3;
        for (int b = 2; b >= 0; b--) if (m_mask[b]) fb = b;
        m_nb = (ABORT && fb < 3) ? fb + 1 : 3;
        m_nflag = 0;
        for (int b = 0; b < m_nb; b++) if (m_mask[b]) m_nflag = 1;
        m_p = 1 + 18 * m_nb + 3;
      end
    end
    chk("scl", sclk, e_scl);
    if (e_sda_chk) chk("sda", sda_bus, e_sda);
    chk("oen", oen, e_oen);
    chk("busy", busy, e_busy);
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("done0", done0, e_d0);
    chk("done1", done1, e_d1);
    chk("nack", nack, e_nk);
    if (gnt0) begin gq.push_back(0); last_gnt_cyc = cyc; end
    if (gnt1) begin gq.push_back(1); last_gnt_cyc = cyc; end
    if (done0 || done1) last_done_cyc = cyc;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int port);
    bit ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if ((port == 0 && gnt0) || (port == 1 && gnt1)) ok = 1;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (done0 || done1) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int capn0, ackn0, g0s, nsnap;
    bit got0, got1;
    rst_n = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    slave_val = 0; nack_mask = 3'b000;
    step(4);
    rst_n = 1;
    step(20);

    // Single write, slave ACKs every byte; data changes after grant must not matter.
    capn0 = capn; ackn0 = ackn;
    data0 = 24'h341E00; nack_mask = 3'b000; req0 = 1;
    wait_gnt(0);
    req0 = 0; data0 = 24'hFFFFFF;
    wait_done();
    chk("lat_ack_all", last_done_cyc - last_gnt_cyc, 233);
    chk("bit_count", capn - capn0, 25);
    chk("bits_341E00", cap[24:1], 24'h341E00);
    chk("stop_low_bit", cap[0], 0);
    chk("ack_windows", ackn - ackn0, 3);
    step(5);

    // Simultaneous requests twice after reset: expect 0,1,0,1.
    rst_n = 0; step(2); rst_n = 1; step(3);
    g0s = gq.size();
    data0 = 24'h112233; data1 = 24'hA5C3F0;
    for (int r = 0; r < 2; r++) begin
      req0 = 1; req1 = 1; got0 = 0; got1 = 0;
      for (int c = 0; c < 1200 && !(got0 && got1); c++) begin
        @(negedge clk);
        if (gnt0) got0 = 1;
        if (gnt1) got1 = 1;
        @(posedge clk); #1;
        if (got0) req0 = 0;
        if (got1) req1 = 0;
      end
      if (!(got0 && got1)) chk("tie_timeout", 0, 1);
      req0 = 0; req1 = 0;
      wait_done();
    end
    chk("tie_ngnt", gq.size() - g0s, 4);
    if (gq.size() - g0s == 4) begin
      chk("tie_g0", gq[g0s], 0);
      chk("tie_g1", gq[g0s + 1], 1);
      chk("tie_g2", gq[g0s + 2], 0);
      chk("tie_g3", gq[g0s + 3], 1);
    end
    step(3);

    // Slave NACKs the second byte.
    data0 = 24'h340C00; nack_mask = 3'b010; req0 = 1;
    wait_gnt(0);
    req0 = 0;
    wait_done();
    chk("lat_nack_b1", last_done_cyc - last_gnt_cyc, ABORT ? 161 : 233);
    nack_mask = 3'b000;
    step(3);

    // Reset during byte 1, then a fresh port-1 write.
    data0 = 24'h5A5A5A; req0 = 1;
    wait_gnt(0);
    req0 = 0;
    step(21 * DIV);
    rst_n = 0;
    step(3);
    rst_n = 1;
    step(300);
    data1 = 24'h1A2B3C; req1 = 1;
    wait_gnt(1);
    req1 = 0;
    wait_done();
    chk("lat_after_rst", last_done_cyc - last_gnt_cyc, 233);
    step(3);

    // A one-cycle req1 during a busy frame is cancelled.
    data0 = 24'h0F0F0F; req0 = 1;
    wait_gnt(0);
    req0 = 0;
    nsnap = gq.size();
    step(20);
    req1 = 1;
    step(1);
    req1 = 0;
    wait_done();
    step(30);
    chk("cancel_no_gnt", gq.size() - nsnap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2c_write_arbiter.md
# i2c_write_arbiter

Shares the single I2C control bus to the audio codec between two register-write requesters: the power-up initializer sequence and the runtime configuration writer (volume, sample-rate changes). It arbitrates round-robin, latches one 24-bit frame (device address byte + two register bytes), and serializes it onto SCL/SDA with start, per-byte ACK check and stop. It sits between the control FSMs and the codec I2C pins.

## Interface
- `DIV`, 4: system clocks per SCL half-period (phase); legal range ≥ 2.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req0`, `i_req1` in 1: write requests; held high until granted.
- `i_data0`, `i_data1` in 24: frame, bits [23:16] sent first, MSB first within each byte.
- `o_gnt0`, `o_gnt1` out 1: one-cycle pulse when the frame is latched.
- `o_done0`, `o_done1` out 1: one-cycle pulse when the granted transaction completes.
- `o_nack` out 1: one-cycle pulse coincident with done if any byte got NACK.
- `o_busy` out 1: high from the cycle after grant through the done cycle.
- `o_sclk` out 1: I2C clock.
- `o_sdat` inout 1: I2C data; driven with the SDA register when `o_oen`=1, else high-Z.
- `o_oen` out 1: 1 = block drives SDA; 0 only during ACK bits.

## Operation
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: SCL=1, SDA=1, oen=1. If any req is high, grant one; latch its data; pulse its gnt; go to START next cycle.
- Arbitration: round-robin on a last-served pointer. After reset, port 0 wins a tie. After serving port N, port 1-N wins the next tie. A single requester always wins.
- START: 1 phase with SCL=1, SDA=0.
- BIT: 2 phases per bit.
  - Low phase: SCL=0, SDA=current bit, set on the phase's first cycle.
  - High phase: SCL=1.
  - 8 bits per byte, then ACK.
- ACK: 2 phases with oen=0.
  - SDA is sampled on the last cycle of the high phase.
  - Sampled 1 = NACK; it sets a sticky nack flag.
  - After bytes 0 and 1, go to BIT (next byte). After byte 2, go to STOP.
- STOP: 3 phases.
  - Phase 1: SCL=0, SDA=0.
  - Phase 2: SCL=1, SDA=0.
  - Phase 3: SCL=1, SDA=1.
- DONE: 1 cycle.
  - Pulse done for the served port, and nack if the flag is set.
  - Clear the flag, update the pointer, return to IDLE.
  - A new grant is possible in the IDLE cycle that follows.
- A requester dropping req before its grant cancels the request; no transaction runs.
- Data changes after grant are ignored.

## Timing
- Reset values (async, immediate, including mid-transaction): SCL=1, SDA reg=1, oen=1, all gnt/done/nack=0, busy=0, pointer selects port 0, state IDLE, nack flag clear.
- Reset mid-frame leaves the frame truncated; no done is issued.
- Grant at cycle T. START begins at T+1.
- Phase count from START through the end of STOP: 1 + 27×2 + 3 = 58 phases.
- Done pulses at T+1+58·DIV; with DIV=4 that is T+233.
- Next grant is no earlier than done+1.
- `o_busy` covers T+1 through the done cycle inclusive.
- A phase counter runs 0..DIV-1 and advances to the next phase at DIV-1.
- Bit counter 0..7, byte counter 0..2; both wrap to 0 at frame end.

## Configuration
- `I2C_ABORT_ON_NACK_EN` defined:
  - A NACK on any byte jumps from that ACK directly to STOP.
  - Remaining bytes are skipped; done and nack still pulse.
  - Latency is shortened by 18 phases per skipped byte.
- Undefined: all three bytes are always sent; NACK only reported.

## Test plan
- Reset held, then released with no req: SCL=1, `o_sdat`=1, oen=1, busy=0 indefinitely.
- req0 with 0x34_1E00, slave ACKs all bytes, DIV=4:
  - gnt0 at T.
  - SDA sequence 0,0,1,1,0,1,0,0 / 0,0,0,1,1,1,1,0 / 0×8 sampled on SCL rising edges.
  - oen=0 on 3 ACK bits; done0 at T+233; nack=0.
- req0 and req1 asserted in the same cycle, twice in succession:
  - Grants are port 0, port 1, port 0, port 1.
  - No gnt occurs while busy.
- Slave NACKs byte 1 of 0x34_0C00:
  - Without macro: 27 bits sent; done and nack at T+233.
  - With `I2C_ABORT_ON_NACK_EN`: STOP follows byte 1's ACK; done and nack at T+1+40·DIV = T+161.
- i_rst_n pulled low during byte 1 of an active frame:
  - Outputs reach reset values in the same cycle, with no done pulse.
  - After release, a fresh req1 is granted and completes normally.
- req1 raised for one cycle while busy, then dropped: no gnt1 and no transaction after the current done.
